// File: rtl/a_skew_feeder.sv
// Diagonal skew stage feeding the west edge of the systolic array: lane i is delayed by
// i extra cycles, lanes at or above the active row count are masked, and each burst drains with zeros.
module a_skew_feeder #(
   parameter int ARRAY_N         = 8,
   parameter int ACT_WIDTH       = 8,
   parameter int IBUF_DATA_WIDTH = ARRAY_N * ACT_WIDTH
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         act_valid_in,
   input  logic [$clog2(ARRAY_N):0]     num_rows,
   input  logic [IBUF_DATA_WIDTH-1:0]   act_data_set_in,
   output logic [IBUF_DATA_WIDTH-1:0]   act_data_skewed_out,
   output logic [ARRAY_N-1:0]           lane_valid_out,
   output logic                         busy,
   output logic                         drain_done
);

   localparam int RW = $clog2(ARRAY_N) + 1;
   localparam logic [RW-1:0] ROWS_MAX   = RW'(ARRAY_N);
   localparam logic [RW-1:0] DRAIN_LAST = RW'(ARRAY_N - 2);

   typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

   state_t          state_q, state_d;
   logic [RW-1:0]   rows_q, rows_d;
   logic [RW-1:0]   drain_cnt, drain_cnt_d;
   logic            drain_done_d;
   logic [RW-1:0]   sat_rows;
   logic [RW-1:0]   eff_rows;

   // The first vector of a burst is sampled on the same edge that latches rows_q,
   // so in IDLE the mask must come straight from the saturated input.
   assign sat_rows = (num_rows > ROWS_MAX) ? ROWS_MAX : num_rows;
   assign eff_rows = (state_q == IDLE) ? sat_rows : rows_q;
   assign busy     = (state_q != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         rows_q     <= '0;
         drain_cnt  <= '0;
         drain_done <= 1'b0;
      end else begin
         state_q    <= state_d;
         rows_q     <= rows_d;
         drain_cnt  <= drain_cnt_d;
         drain_done <= drain_done_d;
      end
   end

   // Drain ends on the edge where the deepest lane's last element leaves, ARRAY_N-1
   // edges after entering DRAIN; a new vector on that same edge resumes streaming instead.
   always_comb begin
      state_d      = state_q;
      rows_d       = rows_q;
      drain_cnt_d  = drain_cnt;
      drain_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (act_valid_in) begin
               state_d = STREAM;
               rows_d  = sat_rows;
            end
         end
         STREAM: begin
            if (!act_valid_in) begin
               state_d     = DRAIN;
               drain_cnt_d = '0;
            end
         end
         DRAIN: begin
            if (act_valid_in) begin
               state_d     = STREAM;
               drain_cnt_d = '0;
            end else if (drain_cnt == DRAIN_LAST) begin
               state_d      = IDLE;
               drain_done_d = 1'b1;
            end else begin
               drain_cnt_d = drain_cnt + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   for (genvar i = 0; i < ARRAY_N; i++) begin : g_lane
      localparam logic [RW-1:0] LANE = RW'(i);

      logic [ACT_WIDTH-1:0] data_q [i+1];
      logic                 vld_q  [i+1];
      logic                 feed_v;

      assign feed_v = act_valid_in && (LANE < eff_rows);

      // Masked or idle slots shift zeros so an invalid lane always reads as zero.
      always_ff @(posedge clk) begin
         if (reset) begin
            for (int s = 0; s <= i; s++) begin
               data_q[s] <= '0;
               vld_q[s]  <= 1'b0;
            end
         end else begin
            data_q[0] <= feed_v ? act_data_set_in[i*ACT_WIDTH +: ACT_WIDTH] : '0;
            vld_q[0]  <= feed_v;
            for (int s = 1; s <= i; s++) begin
               data_q[s] <= data_q[s-1];
               vld_q[s]  <= vld_q[s-1];
            end
         end
      end

      assign act_data_skewed_out[i*ACT_WIDTH +: ACT_WIDTH] = data_q[i];
      assign lane_valid_out[i] = vld_q[i];
   end

endmodule

// File: tb/tb_a_skew_feeder.sv
// Self-checking bench for a_skew_feeder: a scoreboard queue of expected per-lane outputs
// plus per-cycle busy/drain_done expectations from a table and hand-written sequences.
module tb_a_skew_feeder;

   localparam int N = 8;
   localparam int W = 8;

   logic          clk;
   logic          reset;
   logic          act_valid_in;
   logic [3:0]    num_rows;
   logic [63:0]   act_data_set_in;
   logic [63:0]   act_data_skewed_out;
   logic [7:0]    lane_valid_out;
   logic          busy;
   logic          drain_done;

   a_skew_feeder #(.ARRAY_N(N), .ACT_WIDTH(W), .IBUF_DATA_WIDTH(N*W)) dut (
      .clk                 (clk),
      .reset               (reset),
      .act_valid_in        (act_valid_in),
      .num_rows            (num_rows),
      .act_data_set_in     (act_data_set_in),
      .act_data_skewed_out (act_data_skewed_out),
      .lane_valid_out      (lane_valid_out),
      .busy                (busy),
      .drain_done          (drain_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int         cyc;
      int         lane;
      logic [7:0] data;
   } sb_t;

   typedef struct {
      logic        v;
      logic [3:0]  nr;
      logic [63:0] d;
      int          mrows;
      logic        xbusy;
      logic        xdone;
   } vec_t;

   sb_t  sb[$];
   int   edge_no = 0;
   int   total = 0;
   int   bad = 0;

   function automatic logic [63:0] mkvec(input int base, input int stride);
      logic [63:0] r;
      r = '0;
      for (int i = 0; i < N; i++) r[i*W +: W] = 8'(base + stride * i);
      return r;
   endfunction

   task automatic checkOutput(input string nm, input logic xbusy, input logic xdone);
      logic [63:0] exp_data;
      logic [7:0]  exp_vld;
      exp_data = '0;
      exp_vld  = '0;
      for (int k = sb.size() - 1; k >= 0; k--) begin
         if (sb[k].cyc == edge_no) begin
            exp_data[sb[k].lane*W +: W] = sb[k].data;
            exp_vld[sb[k].lane]         = 1'b1;
            sb.delete(k);
         end
      end
      total++;
      if (act_data_skewed_out !== exp_data) begin
         bad++;
         $display("[TB] FAIL %s data edge=%0d got=%h exp=%h", nm, edge_no, act_data_skewed_out, exp_data);
      end
      total++;
      if (lane_valid_out !== exp_vld) begin
         bad++;
         $display("[TB] FAIL %s lane_valid edge=%0d got=%b exp=%b", nm, edge_no, lane_valid_out, exp_vld);
      end
      total++;
      if (busy !== xbusy) begin
         bad++;
         $display("[TB] FAIL %s busy edge=%0d got=%b exp=%b", nm, edge_no, busy, xbusy);
      end
      total++;
      if (drain_done !== xdone) begin
         bad++;
         $display("[TB] FAIL %s drain_done edge=%0d got=%b exp=%b", nm, edge_no, drain_done, xdone);
      end
   endtask

   // One clock edge: drive inputs, record what each active lane should show i edges later,
   // then check the cycle right after the edge.
   task automatic applyStimulus(input logic r, input logic v, input logic [3:0] nr,
                                input logic [63:0] d, input int mrows,
                                input logic xbusy, input logic xdone, input string nm);
      reset           = r;
      act_valid_in    = v;
      num_rows        = nr;
      act_data_set_in = d;
      @(posedge clk);
      edge_no++;
      if (r) begin
         sb.delete();
      end else if (v) begin
         for (int i = 0; i < mrows; i++) begin
            sb.push_back('{cyc: edge_no + i, lane: i, data: d[i*W +: W]});
         end
      end
      #1;
      checkOutput(nm, xbusy, xdone);
   endtask

   task automatic drainCheck(input string nm);
      for (int j = 1; j <= N; j++) applyStimulus(1'b0, 1'b0, 4'd0, '0, 0, j < N, j == N, nm);
      applyStimulus(1'b0, 1'b0, 4'd0, '0, 0, 1'b0, 1'b0, nm);
   endtask

   vec_t tbl[10];

   initial begin
      reset = 1'b1;
      act_valid_in = 1'b0;
      num_rows = 4'd0;
      act_data_set_in = '0;

      applyStimulus(1'b1, 1'b0, 4'd0, '0, 0, 1'b0, 1'b0, "reset");
      applyStimulus(1'b1, 1'b1, 4'd8, mkvec(1, 1), 0, 1'b0, 1'b0, "reset_in");
      applyStimulus(1'b0, 1'b0, 4'd8, '0, 0, 1'b0, 1'b0, "post_reset");

      tbl[0] = '{v: 1'b1, nr: 4'd8, d: mkvec(8'h10, 1), mrows: 8, xbusy: 1'b1, xdone: 1'b0};
      for (int j = 1; j < 10; j++)
         tbl[j] = '{v: 1'b0, nr: 4'd8, d: '0, mrows: 0, xbusy: (j < 8), xdone: (j == 8)};
      for (int j = 0; j < 10; j++)
         applyStimulus(1'b0, tbl[j].v, tbl[j].nr, tbl[j].d, tbl[j].mrows,
                       tbl[j].xbusy, tbl[j].xdone, "single");

      for (int k = 0; k < 16; k++) applyStimulus(1'b0, 1'b1, 4'd4, mkvec(16*k, 1), 4, 1'b1, 1'b0, "burst16");
      drainCheck("burst16_drain");

      for (int k = 0; k < 8; k++)
         applyStimulus(1'b0, 1'b1, (k < 4) ? 4'd4 : 4'd8, mkvec(32*k + 3, 1), 4, 1'b1, 1'b0, "rows_change");
      drainCheck("rows_change_drain");
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 4'd8, mkvec(100 + k, 2), 8, 1'b1, 1'b0, "rows_next");
      drainCheck("rows_next_drain");

      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 4'd8, mkvec(40 + k, 3), 8, 1'b1, 1'b0, "gap_a");
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b0, 4'd8, '0, 0, 1'b1, 1'b0, "gap_idle");
      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 4'd2, mkvec(80 + k, 5), 8, 1'b1, 1'b0, "gap_b");
      drainCheck("gap_drain");

      applyStimulus(1'b0, 1'b1, 4'd8, mkvec(7, 9), 8, 1'b1, 1'b0, "edge_resume");
      for (int k = 0; k < N - 1; k++) applyStimulus(1'b0, 1'b0, 4'd8, '0, 0, 1'b1, 1'b0, "edge_wait");
      applyStimulus(1'b0, 1'b1, 4'd8, mkvec(200, 1), 8, 1'b1, 1'b0, "edge_restart");
      drainCheck("edge_drain");

      for (int k = 0; k < 3; k++) applyStimulus(1'b0, 1'b1, 4'd8, mkvec(60 + k, 1), 8, 1'b1, 1'b0, "mid_reset_burst");
      applyStimulus(1'b1, 1'b1, 4'd8, mkvec(9, 1), 0, 1'b0, 1'b0, "mid_reset");
      for (int k = 0; k < 10; k++) applyStimulus(1'b0, 1'b0, 4'd8, '0, 0, 1'b0, 1'b0, "after_reset");

      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 4'd0, mkvec(90 + k, 1), 0, 1'b1, 1'b0, "rows0");
      drainCheck("rows0_drain");
      for (int k = 0; k < 2; k++) applyStimulus(1'b0, 1'b1, 4'd15, mkvec(150 + k, 1), 8, 1'b1, 1'b0, "rows15");
      drainCheck("rows15_drain");

      total++;
      if (sb.size() != 0) begin
         bad++;
         $display("[TB] FAIL scoreboard_empty got=%0d exp=0", sb.size());
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog got=timeout exp=finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
